strassen_seq_ctrl: RTL and testbench
====================================

Name: strassen_seq_ctrl

Overview:
- Sequencer for the Strassen 2x2-block multiply datapath, built from the team's enable-gated register banks and one shared block multiplier.
- Loads the A/B input registers and steps through the seven products M1..M7: operand pre-add, multiplier launch/wait, product-register writeback.
- Then drives the four C-quadrant combine writes and pulses Done.
- All register-bank En pins in the Strassen datapath come from this block.

Parameters:
TO_W  8  width of multiplier-wait timeout counter
TIMEOUT  200  MUL wait cycles without Mul_done before error; must satisfy 1 <= TIMEOUT <= 2^TO_W-1

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  reset, asynchronous, active-low
Start  input  1  begin a multiply; sampled only in IDLE
Clr  input  1  synchronous abort/clear; any state -> IDLE
Mul_done  input  1  multiplier result valid; sampled only in GO/WAIT
En_in  output  1  enable for A/B input register banks
En_op  output  1  enable for pre-add operand register banks
Op_sel  output  3  pre-add mux select = product index 0..6 (M1..M7)
Mul_go  output  1  one-cycle multiplier launch pulse
En_M  output  7  one-hot product-register enable, bit k = M(k+1)
En_C  output  4  one-hot C-quadrant register enable (C11,C12,C21,C22)
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle completion pulse
Err  output  1  multiplier timeout flag, held until Clr or reset

Behaviour:
- Moore FSM. All outputs are decoded from state/index flops. No combinational path from any input to any output.
- Reset (Rst=0, async): state=IDLE, idx=0, q=0, timeout cnt=0, all outputs 0. Asserting reset mid-operation abandons the sequence with no Done. The first operation after release needs a fresh Start.
- IDLE: Start=1 -> LOAD. Otherwise stay.
- LOAD (1 cycle): En_in=1, idx<=0 -> OPND.
- OPND (1 cycle): En_op=1, Op_sel=idx -> GO.
- GO (1 cycle): Mul_go=1, cnt<=0. Mul_done=1 -> WB; else -> WAIT.
- WAIT: cnt increments each cycle.
  - Mul_done=1 -> WB.
  - Else if cnt reaches TIMEOUT-1 -> ERR.
  - Mul_done in the expiry cycle wins: go to WB, not ERR.
- WB (1 cycle): En_M = 1<<idx.
  - idx==6 -> COMB, q<=0.
  - Else idx<=idx+1 -> OPND.
- COMB (4 cycles): En_C = 1<<q, q increments. Exits after q==3 -> DONE.
- DONE (1 cycle): Done=1 -> IDLE. Start is not accepted in DONE. Back-to-back Start is accepted in the following IDLE cycle.
- ERR: Err=1, Busy=1, all enables 0. Clr -> IDLE. Start is ignored.
- Clr=1 in any state: next state IDLE. This takes priority over all other transitions. No Done is issued, and no enable is asserted in the Clr cycle's successor.
- Op_sel holds idx in every state; it reads 0 in IDLE.
- Mul_done outside GO/WAIT is ignored.
- Start outside IDLE is ignored.
- At most one bit of En_M and at most one bit of En_C is set at any time. En_M and En_C are never set in the same cycle.
- Latency: let the multiplier respond L cycles after the Mul_go cycle (L>=0).
  - Start sampled at edge e0; LOAD is cycle 1.
  - Done is high in cycle 1 + 7(L+3) + 4 + 1.

Test Plan:
- Nominal, L=2: Start pulse -> En_in in cycle 1; Mul_go in cycles 3,8,...,33; En_M 0x01..0x40 in order; En_C 1,2,4,8 in cycles 37-40; Done in cycle 41; Busy high cycles 1-41.
- L=0, Mul_done tied high: GO goes straight to WB each product; Done in cycle 27; no cycle has two enable groups active.
- Timeout, TIMEOUT=4, Mul_done never asserted on M3: ERR entered after 4 wait cycles; Err=1 held; Start ignored; Clr -> IDLE with Err=0 and Busy=0 next cycle.
- Mul_done in exactly the expiry cycle: WB taken, En_M=0x04, no Err.
- Rst low during COMB (q=2): all outputs 0 immediately, no Done; after release a new Start gives a full sequence identical to the nominal case.
- Clr mid-WAIT of M5, and stray Mul_done/Start pulses in IDLE and WB: FSM returns to IDLE with no En_M write for M5; the stray pulses cause no state change.

Source files
------------

// File: rtl/strassen_seq_ctrl.sv
// Moore sequencer for the Strassen 2x2-block multiply datapath: input load, seven
// products M1..M7 (pre-add, multiply, writeback), four C-quadrant combines, Done.
module strassen_seq_ctrl #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       clr_i,
  input  logic       mul_done_i,
  output logic       en_in_o,
  output logic       en_op_o,
  output logic [2:0] op_sel_o,
  output logic       mul_go_o,
  output logic [6:0] en_m_o,
  output logic [3:0] en_c_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_OPND,
    S_GO,
    S_WAIT,
    S_WB,
    S_COMB,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [2:0]      IDX_LAST = 3'd6;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0]      q_q, q_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      q_q     <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    en_in_o  = 1'b0;
    en_op_o  = 1'b0;
    mul_go_o = 1'b0;
    done_o   = 1'b0;
    err_o    = 1'b0;
    busy_o   = (state_q != S_IDLE);
    op_sel_o = idx_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        en_in_o = 1'b1;
        idx_d   = 3'd0;
        state_d = S_OPND;
      end
      S_OPND: begin
        en_op_o = 1'b1;
        state_d = S_GO;
      end
      S_GO: begin
        mul_go_o = 1'b1;
        cnt_d    = '0;
        state_d  = mul_done_i ? S_WB : S_WAIT;
      end
      S_WAIT: begin
        // A result arriving in the expiry cycle still counts as success.
        cnt_d = cnt_q + TO_W'(1);
        if (mul_done_i)            state_d = S_WB;
        else if (cnt_q == TO_LAST) state_d = S_ERR;
      end
      S_WB: begin
        if (idx_q == IDX_LAST) begin
          q_d     = 2'd0;
          state_d = S_COMB;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_OPND;
        end
      end
      S_COMB: begin
        q_d = q_q + 2'd1;
        if (q_q == 2'd3) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        idx_d   = 3'd0;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_o = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_i) begin
      state_d = S_IDLE;
      idx_d   = 3'd0;
      q_d     = 2'd0;
      cnt_d   = '0;
    end
  end

  // Bank enables are one-hot decodes of the writeback index and combine counter.
  for (genvar gi = 0; gi < 7; gi++) begin : g_en_m
    assign en_m_o[gi] = (state_q == S_WB) && (idx_q == 3'(gi));
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_en_c
    assign en_c_o[gi] = (state_q == S_COMB) && (q_q == 2'(gi));
  end

endmodule

// File: tb/tb_strassen_seq_ctrl.sv
// Bench for strassen_seq_ctrl: per-cycle expected traces built from the sequencing
// rules (directed and random latencies, timeouts, aborts) plus an async-reset sequence.
module tb_strassen_seq_ctrl;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic       mul_done = 1'b0;
  logic       en_in, en_op, mul_go, busy, done, err;
  logic [2:0] op_sel;
  logic [6:0] en_m;
  logic [3:0] en_c;

  always #5 clk = ~clk;

  strassen_seq_ctrl #(.TO_W(8), .TIMEOUT(TMO)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .clr_i     (clr),
    .mul_done_i(mul_done),
    .en_in_o   (en_in),
    .en_op_o   (en_op),
    .op_sel_o  (op_sel),
    .mul_go_o  (mul_go),
    .en_m_o    (en_m),
    .en_c_o    (en_c),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  typedef struct packed {
    logic       en_in;
    logic       en_op;
    logic [2:0] op_sel;
    logic       mul_go;
    logic [6:0] en_m;
    logic [3:0] en_c;
    logic       busy;
    logic       done;
    logic       err;
  } outs_t;

  // One record per clock cycle: expected outputs in that cycle and inputs driven during it.
  typedef struct packed {
    logic  first;
    logic  start;
    logic  clr;
    logic  mul_done;
    outs_t exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  function automatic outs_t sample();
    outs_t o;
    o.en_in  = en_in;
    o.en_op  = en_op;
    o.op_sel = op_sel;
    o.mul_go = mul_go;
    o.en_m   = en_m;
    o.en_c   = en_c;
    o.busy   = busy;
    o.done   = done;
    o.err    = err;
    return o;
  endfunction

  task automatic check(input string name, input int idx, input outs_t want);
    outs_t got;
    got = sample();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h (en_m got %h want %h, en_c got %h want %h)",
               name, idx, got, want, got.en_m, want.en_m, got.en_c, want.en_c);
    end
  endtask

  function automatic logic junk(input bit stray);
    return stray ? 1'($urandom_range(1, 0)) : 1'b0;
  endfunction

  task automatic push(input outs_t o, input logic st, input logic cl, input logic md);
    vec_t v;
    v.first    = 1'b0;
    v.start    = st;
    v.clr      = cl;
    v.mul_done = md;
    v.exp      = o;
    vecs.push_back(v);
  endtask

  // Expected trace of one operation. lat[k] = cycles from Mul_go to Mul_done for M(k+1);
  // lat > TMO means the multiplier never answers. clr_at > 0 aborts at that relative cycle.
  task automatic gen_op(input int lat[7], input int clr_at, input bit stray);
    int    base;
    bit    aborted;
    outs_t o;
    vec_t  v;
    base    = vecs.size();
    aborted = 1'b0;

    o = '0;
    push(o, 1'b1, 1'b0, junk(stray));
    v = vecs[base]; v.first = 1'b1; vecs[base] = v;

    o = '0; o.busy = 1'b1; o.en_in = 1'b1;
    push(o, junk(stray), 1'b0, junk(stray));

    for (int k = 0; k < 7 && !aborted; k++) begin
      o = '0; o.busy = 1'b1; o.op_sel = 3'(k); o.en_op = 1'b1;
      push(o, junk(stray), 1'b0, junk(stray));
      o.en_op = 1'b0; o.mul_go = 1'b1;
      push(o, junk(stray), 1'b0, lat[k] == 0);
      o.mul_go = 1'b0;
      if (lat[k] > TMO) begin
        for (int w = 1; w <= TMO; w++) push(o, junk(stray), 1'b0, 1'b0);
        o.err = 1'b1;
        for (int e = 0; e < 4; e++)
          push(o, (e == 1) ? 1'b1 : junk(stray), e == 3, junk(stray));
        aborted = 1'b1;
      end else begin
        for (int w = 1; w <= lat[k]; w++) push(o, junk(stray), 1'b0, w == lat[k]);
        o.en_m = 7'b1 << k;
        push(o, junk(stray), 1'b0, junk(stray));
      end
    end

    if (!aborted) begin
      o = '0; o.busy = 1'b1; o.op_sel = 3'd6;
      for (int q = 0; q < 4; q++) begin
        o.en_c = 4'b1 << q;
        push(o, junk(stray), 1'b0, junk(stray));
      end
      o.en_c = 4'd0; o.done = 1'b1;
      push(o, junk(stray), 1'b0, junk(stray));
    end

    if (clr_at > 0 && base + clr_at < vecs.size() - 1) begin
      v = vecs[base + clr_at]; v.clr = 1'b1; vecs[base + clr_at] = v;
      while (vecs.size() > base + clr_at + 1) void'(vecs.pop_back());
    end
  endtask

  task automatic push_idle();
    outs_t o;
    o = '0;
    push(o, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_vecs(input string name, input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(posedge clk);
      #1;
      if (vecs[i].first) begin
        $display("txn %0d (%s) begins at vector %0d", txn, name, i);
        txn++;
      end
      check(name, i, vecs[i].exp);
      start    = vecs[i].start;
      clr      = vecs[i].clr;
      mul_done = vecs[i].mul_done;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int    lat[7];
    int    clr_at;
    outs_t zero_o;
    zero_o = '0;

    #3;
    check("reset", 0, zero_o);
    #19 rst_n = 1'b1;

    // Directed cases: nominal L=2, L=0, timeout on M3, result in expiry cycle, Clr during M5 wait.
    for (int k = 0; k < 7; k++) lat[k] = 2;
    gen_op(lat, 0, 1'b0);
    for (int k = 0; k < 7; k++) lat[k] = 0;
    gen_op(lat, 0, 1'b1);
    for (int k = 0; k < 7; k++) lat[k] = 2;
    lat[2] = TMO + 1;
    gen_op(lat, 0, 1'b1);
    lat[2] = TMO;
    gen_op(lat, 0, 1'b0);
    lat[2] = 2; lat[4] = 3;
    gen_op(lat, 25, 1'b1);

    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 7; k++)
        lat[k] = ($urandom_range(19, 0) == 0) ? TMO + 1 : int'($urandom_range(TMO, 0));
      clr_at = ($urandom_range(4, 0) == 0) ? int'($urandom_range(60, 1)) : 0;
      gen_op(lat, clr_at, 1'b1);
    end
    push_idle();
    run_vecs("trace", 0, vecs.size());

    // Async reset while combining (q=2), then a fresh nominal sequence.
    start = 1'b0; clr = 1'b0; mul_done = 1'b0;
    vecs.delete();
    for (int k = 0; k < 7; k++) lat[k] = 2;
    gen_op(lat, 0, 1'b0);
    push_idle();
    run_vecs("pre_rst", 0, 40);
    start = 1'b0; clr = 1'b0; mul_done = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("rst_async", 0, zero_o);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1 check("rst_hold", c, zero_o);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("post_rst_idle", 0, zero_o);
    run_vecs("post_rst", 0, vecs.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
